// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, credit-limited imem requests, {pc,instr} FIFO, execute redirect
// Optional: FETCH_MISALIGN_CHECK_EN registers a one-cycle fetch_misaligned pulse on unaligned redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] exe_branch_jump_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        fetch_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic [31:0]   r_aq_mem [DEPTH];
  logic [AW-1:0] r_aq_wr;
  logic [AW-1:0] r_aq_rd;

  logic [31:0]   r_iq_pc    [DEPTH];
  logic [31:0]   r_iq_instr [DEPTH];
  logic [AW-1:0] r_iq_wr;
  logic [AW-1:0] r_iq_rd;
  logic [CW-1:0] r_iq_cnt;

  logic          w_pop;
  logic          w_grant;
  logic          w_push;
  logic [CW:0]   w_used;
  logic [31:0]   w_aq_head;

  assign if_valid  = (r_iq_cnt != '0);
  assign w_pop     = if_valid && if_ready && !pc_src;
  // Credits cover both pending responses and buffered instructions, so the FIFO cannot overflow.
  assign w_used    = {1'b0, r_inflight} + {1'b0, r_iq_cnt} - (CW+1)'(if_valid && if_ready);
  assign imem_req  = !reset && !pc_src && (w_used < (CW+1)'(DEPTH));
  assign imem_addr = r_pc;
  assign w_grant   = imem_req && imem_gnt;
  assign w_push    = imem_rvalid && (r_drop == '0) && !pc_src;
  assign w_aq_head = r_aq_mem[r_aq_rd];

  assign if_pc          = if_valid ? r_iq_pc[r_iq_rd]    : 32'h0;
  assign if_instruction = if_valid ? r_iq_instr[r_iq_rd] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_aq_wr    <= '0;
      r_aq_rd    <= '0;
      r_iq_wr    <= '0;
      r_iq_rd    <= '0;
      r_iq_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_pc    <= r_pc + 32'd4;
        r_aq_wr <= r_aq_wr + 1'b1;
      end
      if (imem_rvalid) begin
        r_aq_rd <= r_aq_rd + 1'b1;
      end
      r_inflight <= r_inflight + CW'(w_grant) - CW'(imem_rvalid);

      if (pc_src) begin
        r_pc     <= {exe_branch_jump_address[31:2], 2'b00};
        // A same-cycle response retires now either way; everything still pending after it is dropped.
        r_drop   <= r_inflight - CW'(imem_rvalid);
        r_iq_wr  <= '0;
        r_iq_rd  <= '0;
        r_iq_cnt <= '0;
      end else begin
        if (imem_rvalid && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
        if (w_push) begin
          r_iq_wr <= r_iq_wr + 1'b1;
        end
        if (w_pop) begin
          r_iq_rd <= r_iq_rd + 1'b1;
        end
        r_iq_cnt <= r_iq_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_aq_mem[r_aq_wr] <= r_pc;
    end
    if (w_push) begin
      r_iq_pc[r_iq_wr]    <= w_aq_head;
      r_iq_instr[r_iq_wr] <= imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= pc_src && (exe_branch_jump_address[1:0] != 2'b00);
    end
  end

  assign fetch_misaligned = r_misaligned;
`else
  logic w_unused_target_lsbs;

  assign w_unused_target_lsbs = ^exe_branch_jump_address[1:0];
  assign fetch_misaligned     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with an in-order variable-latency imem model
// Expects fetch_misaligned pulses only when FETCH_MISALIGN_CHECK_EN is defined.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [31:0] tgt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        fetch_misaligned;

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .pc_src                  (pc_src),
    .exe_branch_jump_address (tgt),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_gnt                (imem_gnt),
    .imem_rvalid             (imem_rvalid),
    .imem_rdata              (imem_rdata),
    .if_valid                (if_valid),
    .if_ready                (if_ready),
    .if_instruction          (if_instruction),
    .if_pc                   (if_pc),
    .fetch_misaligned        (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f_instr(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // In-order memory: a granted address answers lat cycles later.
  int          lat = 1;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  always @(negedge clk) begin
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_rvalid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = f_instr(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  int checks = 0;
  int errors = 0;
  int n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    n++;
    pc_src = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_head(input logic [31:0] pc);
    check("head_valid", {31'h0, if_valid}, 32'h1);
    check("head_pc", if_pc, pc);
    check("head_instr", if_instruction, f_instr(pc));
  endtask

  initial begin
    reset    = 1'b1;
    pc_src   = 1'b0;
    tgt      = 32'h0;
    imem_gnt = 1'b1;
    if_ready = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_instr", if_instruction, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_mis", {31'h0, fetch_misaligned}, 32'h0);

    // Streaming from reset with single-cycle memory
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    smp();
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h100);
    adv(); smp();
    check("c1_valid", {31'h0, if_valid}, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      adv(); smp();
      chk_head(32'h100 + 32'(4 * (k - 2)));
    end

    // Decode stall for 10 cycles; credit runs out two cycles in
    for (int k = 6; k <= 15; k++) begin
      adv(); if_ready = 1'b0; smp();
      check("stall_pc", if_pc, 32'h110);
      check("stall_req", {31'h0, imem_req}, (k < 8) ? 32'h1 : 32'h0);
    end
    for (int k = 16; k <= 21; k++) begin
      adv(); if_ready = 1'b1; smp();
      chk_head(32'h110 + 32'(4 * (k - 16)));
    end

    // Redirect coinciding with a response and a decode pop
    adv(); pc_src = 1'b1; tgt = 32'h400; smp();
    check("rd_req", {31'h0, imem_req}, 32'h0);
    check("rd_rvalid", {31'h0, imem_rvalid}, 32'h1);
    chk_head(32'h128);
    adv(); smp();
    check("rd1_valid", {31'h0, if_valid}, 32'h0);
    check("rd1_req", {31'h0, imem_req}, 32'h1);
    check("rd1_addr", imem_addr, 32'h400);
    adv(); smp();
    check("rd2_valid", {31'h0, if_valid}, 32'h0);
    adv(); smp(); chk_head(32'h400);
    adv(); smp(); chk_head(32'h404);

    // Misaligned redirect target
    adv(); pc_src = 1'b1; tgt = 32'h302; smp();
    check("mis_r", {31'h0, fetch_misaligned}, 32'h0);
    adv(); smp();
    check("mis_r1", {31'h0, fetch_misaligned}, {31'h0, MIS_EN});
    check("mis_addr", imem_addr, 32'h300);
    check("mis_req", {31'h0, imem_req}, 32'h1);
    adv(); smp();
    check("mis_r2", {31'h0, fetch_misaligned}, 32'h0);
    check("mis_valid", {31'h0, if_valid}, 32'h0);
    adv(); smp(); chk_head(32'h300);
    adv(); smp(); chk_head(32'h304);

    // PC wrap across 2^32
    adv(); pc_src = 1'b1; tgt = 32'hFFFF_FFF8; smp();
    adv(); smp();
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    check("wrap_mis", {31'h0, fetch_misaligned}, 32'h0);
    adv(); smp();
    adv(); smp(); chk_head(32'hFFFF_FFF8);
    adv(); smp(); chk_head(32'hFFFF_FFFC);
    adv(); smp(); chk_head(32'h0000_0000);
    adv(); smp(); chk_head(32'h0000_0004);

    // Mid-operation reset, then 3-cycle memory with a redirect over two pending responses
    adv(); reset = 1'b1; smp();
    check("mrst_valid", {31'h0, if_valid}, 32'h0);
    check("mrst_req", {31'h0, imem_req}, 32'h0);
    check("mrst_addr", imem_addr, 32'h100);
    lat = 3;
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    imem_gnt = 1'b1;
    smp();
    adv(); imem_gnt = 1'b1; smp();
    adv(); imem_gnt = 1'b0; pc_src = 1'b1; tgt = 32'h200; smp();
    check("l3_rd_req", {31'h0, imem_req}, 32'h0);
    adv(); imem_gnt = 1'b1; smp();
    check("l3_req", {31'h0, imem_req}, 32'h1);
    check("l3_addr", imem_addr, 32'h200);
    check("l3_valid3", {31'h0, if_valid}, 32'h0);
    adv(); smp();
    check("l3_valid4", {31'h0, if_valid}, 32'h0);
    adv(); smp();
    check("l3_valid5", {31'h0, if_valid}, 32'h0);
    adv(); smp();
    check("l3_valid6", {31'h0, if_valid}, 32'h0);
    check("l3_rvalid6", {31'h0, imem_rvalid}, 32'h1);
    adv(); smp(); chk_head(32'h200);
    adv(); smp(); chk_head(32'h204);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
